// File: rtl/six_instr_control_unit.sv
// Multi-cycle Moore control unit for the six-instruction 16-bit processor: owns PC and IR.
// Define CTRL_HALT_EN to decode opcode 7 as HALT (otherwise it executes as NOOP).
module six_instr_control_unit #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned D_AW = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     IR_in,
  input  logic            RF_Ra_zero,
  output logic [PC_W-1:0] I_Addr,
  output logic [D_AW-1:0] D_Addr,
  output logic            D_Rd,
  output logic            D_Wr,
  output logic [1:0]      RF_s,
  output logic [7:0]      RF_W_data,
  output logic            RF_W_en,
  output logic [3:0]      RF_W_addr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      ALU_s,
  output logic [3:0]      State_out
);

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_NOOP   = 4'd3;
  localparam logic [3:0] ST_LOAD_A = 4'd4;
  localparam logic [3:0] ST_LOAD_B = 4'd5;
  localparam logic [3:0] ST_STORE  = 4'd6;
  localparam logic [3:0] ST_ADD    = 4'd7;
  localparam logic [3:0] ST_SUB    = 4'd8;
  localparam logic [3:0] ST_LDI    = 4'd9;
  localparam logic [3:0] ST_JNZ    = 4'd10;
  localparam logic [3:0] ST_HALT   = 4'd11;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_LDI   = 4'd5;
  localparam logic [3:0] OP_JNZ   = 4'd6;
`ifdef CTRL_HALT_EN
  localparam logic [3:0] OP_HALT  = 4'd7;
`endif

  localparam logic [2:0] ALU_ADD  = 3'h0;
  localparam logic [2:0] ALU_SUB  = 3'h1;
  localparam logic [2:0] ALU_PASS = 3'h3;
  localparam logic [2:0] ALU_IDLE = 3'h7;

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      opcode;
  logic [7:0]      addr_field;
  logic signed [7:0] offset;
  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] jump_target;

  assign opcode     = ir[15:12];
  assign addr_field = ir[7:0];
  assign offset     = ir[7:0];
  // Signed size cast sign-extends the 8-bit offset (or truncates it for narrow PCs).
  assign offset_ext  = PC_W'(offset);
  // PC already points past the JNZ, so the branch base is PC-1.
  assign jump_target = pc - PC_W'(1) + offset_ext;

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  state_next = ST_NOOP;
          OP_STORE: state_next = ST_STORE;
          OP_LOAD:  state_next = ST_LOAD_A;
          OP_ADD:   state_next = ST_ADD;
          OP_SUB:   state_next = ST_SUB;
          OP_LDI:   state_next = ST_LDI;
          OP_JNZ:   state_next = ST_JNZ;
`ifdef CTRL_HALT_EN
          OP_HALT:  state_next = ST_HALT;
`endif
          default:  state_next = ST_NOOP;
        endcase
      end
      ST_LOAD_A: state_next = ST_LOAD_B;
      ST_LOAD_B, ST_NOOP, ST_STORE, ST_ADD, ST_SUB, ST_LDI, ST_JNZ:
                 state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_INIT: begin
          pc <= '0;
          ir <= '0;
        end
        ST_FETCH: begin
          ir <= IR_in;
          pc <= pc + PC_W'(1);
        end
        ST_JNZ: begin
          if (!RF_Ra_zero) pc <= jump_target;
        end
        default: ;
      endcase
    end
  end

  assign I_Addr    = pc;
  assign State_out = state;

  always_comb begin
    D_Addr     = '0;
    D_Rd       = 1'b0;
    D_Wr       = 1'b0;
    RF_s       = 2'd0;
    RF_W_data  = '0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_IDLE;
    case (state)
      ST_STORE: begin
        D_Addr     = D_AW'(addr_field);
        RF_Ra_addr = ir[11:8];
        ALU_s      = ALU_PASS;
        D_Wr       = 1'b1;
      end
      ST_LOAD_A: begin
        D_Addr = D_AW'(addr_field);
        D_Rd   = 1'b1;
      end
      ST_LOAD_B: begin
        D_Addr    = D_AW'(addr_field);
        D_Rd      = 1'b1;
        RF_s      = 2'd1;
        RF_W_addr = ir[11:8];
        RF_W_en   = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        RF_W_addr  = ir[3:0];
        RF_s       = 2'd0;
        RF_W_en    = 1'b1;
        ALU_s      = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      ST_LDI: begin
        RF_s      = 2'd2;
        RF_W_data = addr_field;
        RF_W_addr = ir[11:8];
        RF_W_en   = 1'b1;
      end
      ST_JNZ: begin
        RF_Ra_addr = ir[11:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_six_instr_control_unit.sv
// Randomized self-checking bench: an instruction-level model predicts every cycle's outputs.
module tb_six_instr_control_unit;
  localparam int unsigned PC_W = 8;
  localparam int unsigned D_AW = 8;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [15:0]     IR_in;
  logic            RF_Ra_zero;
  logic [PC_W-1:0] I_Addr;
  logic [D_AW-1:0] D_Addr;
  logic            D_Rd;
  logic            D_Wr;
  logic [1:0]      RF_s;
  logic [7:0]      RF_W_data;
  logic            RF_W_en;
  logic [3:0]      RF_W_addr;
  logic [3:0]      RF_Ra_addr;
  logic [3:0]      RF_Rb_addr;
  logic [2:0]      ALU_s;
  logic [3:0]      State_out;

  six_instr_control_unit #(.PC_W(PC_W), .D_AW(D_AW)) dut (
    .Clock(Clock), .Reset(Reset), .IR_in(IR_in), .RF_Ra_zero(RF_Ra_zero),
    .I_Addr(I_Addr), .D_Addr(D_Addr), .D_Rd(D_Rd), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_data(RF_W_data), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s(ALU_s),
    .State_out(State_out)
  );

  always #5 Clock = ~Clock;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Model state: the program counter as the programmer sees it.
  logic [7:0] mpc;
  logic [3:0] e_state;
  logic [7:0] e_iaddr, e_daddr, e_wdata;
  logic       e_drd, e_dwr, e_wen;
  logic [1:0] e_rfs;
  logic [3:0] e_waddr, e_ra, e_rb;
  logic [2:0] e_alu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic expect_idle(input logic [3:0] st);
    e_state = st;   e_iaddr = mpc;  e_daddr = 8'h00; e_wdata = 8'h00;
    e_drd   = 1'b0; e_dwr   = 1'b0; e_wen   = 1'b0;  e_rfs   = 2'd0;
    e_waddr = 4'h0; e_ra    = 4'h0; e_rb    = 4'h0;  e_alu   = 3'h7;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".state"},  32'(State_out),  32'(e_state));
    check({ph, ".i_addr"}, 32'(I_Addr),     32'(e_iaddr));
    check({ph, ".d_addr"}, 32'(D_Addr),     32'(e_daddr));
    check({ph, ".d_rd"},   32'(D_Rd),       32'(e_drd));
    check({ph, ".d_wr"},   32'(D_Wr),       32'(e_dwr));
    check({ph, ".rf_s"},   32'(RF_s),       32'(e_rfs));
    check({ph, ".w_data"}, 32'(RF_W_data),  32'(e_wdata));
    check({ph, ".w_en"},   32'(RF_W_en),    32'(e_wen));
    check({ph, ".w_addr"}, 32'(RF_W_addr),  32'(e_waddr));
    check({ph, ".ra"},     32'(RF_Ra_addr), 32'(e_ra));
    check({ph, ".rb"},     32'(RF_Rb_addr), 32'(e_rb));
    check({ph, ".alu"},    32'(ALU_s),      32'(e_alu));
  endtask

  // Called at a falling edge; leaves the DUT in INIT at the next falling edge.
  task automatic do_reset();
    Reset = 1'b1;
    mpc = 8'h00;
    #1;
    expect_idle(4'd0);
    compare_all("reset");
    @(negedge Clock);
    Reset = 1'b0;
    expect_idle(4'd0);
    compare_all("init");
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic zero, input bit abort_mid);
    logic signed [7:0] off;
    off = instr[7:0];
    @(negedge Clock);
    expect_idle(4'd1);
    compare_all("fetch");
    IR_in = instr;
    mpc = mpc + 8'd1;
    @(negedge Clock);
    expect_idle(4'd2);
    compare_all("decode");
    IR_in = 16'($urandom);
    RF_Ra_zero = 1'($urandom);
    @(negedge Clock);
    case (instr[15:12])
      4'd1: begin
        expect_idle(4'd6); e_daddr = instr[7:0]; e_ra = instr[11:8];
        e_alu = 3'h3; e_dwr = 1'b1;
        compare_all("store");
      end
      4'd2: begin
        expect_idle(4'd4); e_daddr = instr[7:0]; e_drd = 1'b1;
        compare_all("load_a");
        IR_in = 16'($urandom);
        @(negedge Clock);
        expect_idle(4'd5); e_daddr = instr[7:0]; e_drd = 1'b1;
        e_rfs = 2'd1; e_waddr = instr[11:8]; e_wen = 1'b1;
        compare_all("load_b");
        if (abort_mid) do_reset();
      end
      4'd3, 4'd4: begin
        expect_idle((instr[15:12] == 4'd3) ? 4'd7 : 4'd8);
        e_ra = instr[11:8]; e_rb = instr[7:4]; e_waddr = instr[3:0];
        e_wen = 1'b1; e_alu = (instr[15:12] == 4'd3) ? 3'h0 : 3'h1;
        compare_all("arith");
      end
      4'd5: begin
        expect_idle(4'd9); e_rfs = 2'd2; e_wdata = instr[7:0];
        e_waddr = instr[11:8]; e_wen = 1'b1;
        compare_all("ldi");
      end
      4'd6: begin
        expect_idle(4'd10); e_ra = instr[11:8];
        compare_all("jnz");
        RF_Ra_zero = zero;
        if (!zero) mpc = 8'(int'(mpc) - 1 + int'(off));
      end
`ifdef CTRL_HALT_EN
      4'd7: begin
        for (int i = 0; i < 12; i++) begin
          if (i > 0) @(negedge Clock);
          expect_idle(4'd11);
          compare_all("halt");
          IR_in = 16'($urandom);
          RF_Ra_zero = 1'($urandom);
        end
        do_reset();
      end
`endif
      default: begin
        expect_idle(4'd3);
        compare_all("noop");
      end
    endcase
    IR_in = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [15:0] instr;
    IR_in = 16'h0000;
    RF_Ra_zero = 1'b0;
    do_reset();

    run_instr(16'h0000, 1'b0, 1'b0);
    run_instr(16'h5A3C, 1'b0, 1'b0);
    run_instr(16'h3125, 1'b0, 1'b0);
    run_instr(16'h4125, 1'b0, 1'b0);
    run_instr(16'h2710, 1'b0, 1'b0);
    run_instr(16'h1780, 1'b0, 1'b0);

    // JNZ at PC=5 with offset -3, taken and not taken.
    do_reset();
    repeat (5) run_instr(16'h0000, 1'b0, 1'b0);
    run_instr(16'h61FD, 1'b0, 1'b0);
    check("jnz_taken_pc", 32'(mpc), 32'd2);
    do_reset();
    repeat (5) run_instr(16'h0000, 1'b0, 1'b0);
    run_instr(16'h61FD, 1'b1, 1'b0);

    // Backward wrap below zero, then forward wrap past the top.
    do_reset();
    run_instr(16'h61FF, 1'b0, 1'b0);
    run_instr(16'h0000, 1'b0, 1'b0);
    run_instr(16'h6300, 1'b0, 1'b0);

    // Reset lands in the middle of LOAD_B.
    do_reset();
    run_instr(16'h2710, 1'b0, 1'b1);
    run_instr(16'h7000, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      instr = {4'($urandom_range(0, 9)), 12'($urandom)};
      run_instr(instr, 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
